// File: rtl/idma_page_splitter.sv
// idma_page_splitter
// Cuts flattened 1D transfer requests into chunks that never cross a page
// boundary on either the source or the destination side, and never exceed
// the chunk length cap. Chunks are emitted one per cycle over valid/ready.
module idma_page_splitter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int OPT_WIDTH       = 8,
    parameter int PAGE_BYTES      = 4096,
    parameter int MAX_CHUNK_BYTES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    input  logic [ADDR_WIDTH-1:0] req_src_i,
    input  logic [ADDR_WIDTH-1:0] req_dst_i,
    input  logic [ADDR_WIDTH-1:0] req_num_bytes_i,
    input  logic [OPT_WIDTH-1:0]  req_opt_i,
    output logic                  chunk_valid_o,
    input  logic                  chunk_ready_i,
    output logic [ID_WIDTH-1:0]   chunk_id_o,
    output logic [ADDR_WIDTH-1:0] chunk_src_o,
    output logic [ADDR_WIDTH-1:0] chunk_dst_o,
    output logic [ADDR_WIDTH-1:0] chunk_len_o,
    output logic [OPT_WIDTH-1:0]  chunk_opt_o,
    output logic                  chunk_last_o,
    output logic                  busy_o
);

    // Page offset width; page remainders need one extra bit to hold a full page.
    localparam int PW = $clog2(PAGE_BYTES);

    localparam logic [PW:0]           PAGE_L = (PW + 1)'(PAGE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] MAX_L  = ADDR_WIDTH'(MAX_CHUNK_BYTES);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_rem;
    logic [ID_WIDTH-1:0]   r_id;
    logic [OPT_WIDTH-1:0]  r_opt;

    logic [PW:0]           w_src_page_rem;
    logic [PW:0]           w_dst_page_rem;
    logic [ADDR_WIDTH-1:0] w_len;
    logic                  w_last;
    logic                  w_chunk_valid;
    logic                  w_chunk_fire;
    logic                  w_req_ready;
    logic                  w_req_fire;
    logic                  w_req_nonzero;

    // Unsigned minimum of two address-width values.
    function automatic logic [ADDR_WIDTH-1:0] min_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [ADDR_WIDTH-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    // Chunk length and last flag, derived purely from the working registers.
    always_comb begin
        w_src_page_rem = PAGE_L - {1'b0, r_src[PW-1:0]};
        w_dst_page_rem = PAGE_L - {1'b0, r_dst[PW-1:0]};
        w_len          = min_addr(min_addr(r_rem, MAX_L),
                                  min_addr(ADDR_WIDTH'(w_src_page_rem),
                                           ADDR_WIDTH'(w_dst_page_rem)));
        w_last         = (w_len == r_rem);
    end

    // Handshake qualifiers; a new request may be taken on the last-chunk handshake.
    always_comb begin
        w_chunk_valid = (r_state == S_SPLIT);
        w_chunk_fire  = w_chunk_valid & chunk_ready_i;
        if (rst_i) begin
            w_req_ready = 1'b0;
        end else begin
            w_req_ready = (r_state == S_IDLE) | (w_chunk_fire & w_last);
        end
        w_req_fire    = req_valid_i & w_req_ready;
        w_req_nonzero = (req_num_bytes_i != {ADDR_WIDTH{1'b0}});
    end

    // Next-state selection for the split FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_fire && w_req_nonzero) begin
                    w_next_state = S_SPLIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SPLIT: begin
                if (w_chunk_fire && w_last) begin
                    if (w_req_fire && w_req_nonzero) begin
                        w_next_state = S_SPLIT;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_SPLIT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Working registers: load on request accept, advance on chunk handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src <= {ADDR_WIDTH{1'b0}};
            r_dst <= {ADDR_WIDTH{1'b0}};
            r_rem <= {ADDR_WIDTH{1'b0}};
            r_id  <= {ID_WIDTH{1'b0}};
            r_opt <= {OPT_WIDTH{1'b0}};
        end else if (w_req_fire) begin
            r_src <= req_src_i;
            r_dst <= req_dst_i;
            r_rem <= req_num_bytes_i;
            r_id  <= req_id_i;
            r_opt <= req_opt_i;
        end else if (w_chunk_fire) begin
            r_src <= r_src + w_len;
            r_dst <= r_dst + w_len;
            r_rem <= r_rem - w_len;
        end
    end

    assign req_ready_o   = w_req_ready;
    assign chunk_valid_o = w_chunk_valid;
    assign chunk_id_o    = r_id;
    assign chunk_src_o   = r_src;
    assign chunk_dst_o   = r_dst;
    assign chunk_len_o   = w_len;
    assign chunk_opt_o   = r_opt;
    assign chunk_last_o  = w_chunk_valid & w_last;
    assign busy_o        = (r_state == S_SPLIT);

endmodule

// File: tb/tb_idma_page_splitter.sv
// Directed bench for idma_page_splitter: default instance (4 KiB page/cap)
// and a second instance with a 1 KiB chunk cap, fed from the same inputs.
module tb_idma_page_splitter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_id;
    logic [31:0] req_src;
    logic [31:0] req_dst;
    logic [31:0] req_num;
    logic [7:0]  req_opt;
    logic        chunk_ready;

    logic        req_ready;
    logic        chunk_valid;
    logic [3:0]  chunk_id;
    logic [31:0] chunk_src;
    logic [31:0] chunk_dst;
    logic [31:0] chunk_len;
    logic [7:0]  chunk_opt;
    logic        chunk_last;
    logic        busy;

    logic        m_req_ready;
    logic        m_chunk_valid;
    logic [3:0]  m_chunk_id;
    logic [31:0] m_chunk_src;
    logic [31:0] m_chunk_dst;
    logic [31:0] m_chunk_len;
    logic [7:0]  m_chunk_opt;
    logic        m_chunk_last;
    logic        m_busy;

    int checks;
    int failures;

    idma_page_splitter dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_id_i(req_id), .req_src_i(req_src), .req_dst_i(req_dst),
        .req_num_bytes_i(req_num), .req_opt_i(req_opt),
        .chunk_valid_o(chunk_valid), .chunk_ready_i(chunk_ready),
        .chunk_id_o(chunk_id), .chunk_src_o(chunk_src), .chunk_dst_o(chunk_dst),
        .chunk_len_o(chunk_len), .chunk_opt_o(chunk_opt),
        .chunk_last_o(chunk_last), .busy_o(busy)
    );

    idma_page_splitter #(.MAX_CHUNK_BYTES(1024)) dut_m (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(m_req_ready),
        .req_id_i(req_id), .req_src_i(req_src), .req_dst_i(req_dst),
        .req_num_bytes_i(req_num), .req_opt_i(req_opt),
        .chunk_valid_o(m_chunk_valid), .chunk_ready_i(chunk_ready),
        .chunk_id_o(m_chunk_id), .chunk_src_o(m_chunk_src), .chunk_dst_o(m_chunk_dst),
        .chunk_len_o(m_chunk_len), .chunk_opt_o(m_chunk_opt),
        .chunk_last_o(m_chunk_last), .busy_o(m_busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at the falling edge, expect ready, accept on the rising edge.
    task automatic accept_req(input logic [3:0] id, input logic [31:0] s,
                              input logic [31:0] d, input logic [31:0] n);
        @(negedge clk);
        req_valid   = 1'b1;
        req_id      = id;
        req_src     = s;
        req_dst     = d;
        req_num     = n;
        req_opt     = {4'hA, id};
        chunk_ready = 1'b1;
        #1;
        chk("req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // One cycle of the default instance: expect a valid chunk with the given fields.
    task automatic chunk_cycle(input string tag, input logic rdy, input logic [3:0] id,
                               input logic [31:0] s, input logic [31:0] d,
                               input logic [31:0] l, input logic last);
        @(negedge clk);
        chunk_ready = rdy;
        #1;
        chk({tag, ".valid"}, chunk_valid, 1'b1);
        chk({tag, ".src"},   chunk_src, s);
        chk({tag, ".dst"},   chunk_dst, d);
        chk({tag, ".len"},   chunk_len, l);
        chk({tag, ".last"},  chunk_last, last);
        chk({tag, ".id"},    chunk_id, id);
        chk({tag, ".opt"},   chunk_opt, {4'hA, id});
        chk({tag, ".busy"},  busy, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Expect the default instance idle and ready.
    task automatic expect_idle(input string tag);
        @(negedge clk);
        #1;
        chk({tag, ".valid"}, chunk_valid, 1'b0);
        chk({tag, ".busy"},  busy, 1'b0);
        chk({tag, ".ready"}, req_ready, 1'b1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_id      = 4'h0;
        req_src     = 32'h0;
        req_dst     = 32'h0;
        req_num     = 32'h0;
        req_opt     = 8'h0;
        chunk_ready = 1'b0;

        // Reset state, including ready forced low while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        #1;
        chk("rst.req_ready", req_ready, 1'b0);
        chk("rst.valid", chunk_valid, 1'b0);
        chk("rst.last", chunk_last, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.m_busy", m_busy, 1'b0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_idle("post_rst");

        // Test 3: 1 KiB cap instance, 4 KiB from 0 -> four 0x400 chunks.
        accept_req(4'h3, 32'h0, 32'h0, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chunk_ready = 1'b1;
            #1;
            chk("t3.valid", m_chunk_valid, 1'b1);
            chk("t3.src", m_chunk_src, 32'h400 * i);
            chk("t3.dst", m_chunk_dst, 32'h400 * i);
            chk("t3.len", m_chunk_len, 32'h400);
            chk("t3.last", m_chunk_last, (i == 3) ? 1'b1 : 1'b0);
            chk("t3.busy", m_busy, 1'b1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        chk("t3.end_valid", m_chunk_valid, 1'b0);
        chk("t3.end_busy", m_busy, 1'b0);

        // Test 1: source crosses a page after 0x10 bytes.
        accept_req(4'h1, 32'hFF0, 32'h2000, 32'h40);
        chunk_cycle("t1.c0", 1'b1, 4'h1, 32'hFF0, 32'h2000, 32'h10, 1'b0);
        chunk_cycle("t1.c1", 1'b1, 4'h1, 32'h1000, 32'h2010, 32'h30, 1'b1);
        expect_idle("t1.end");

        // Test 2: destination crosses a page after 0x80 bytes.
        accept_req(4'h2, 32'h100, 32'h1F80, 32'h100);
        chunk_cycle("t2.c0", 1'b1, 4'h2, 32'h100, 32'h1F80, 32'h80, 1'b0);
        chunk_cycle("t2.c1", 1'b1, 4'h2, 32'h180, 32'h2000, 32'h80, 1'b1);
        expect_idle("t2.end");

        // Test 4: zero-length request is swallowed.
        accept_req(4'h4, 32'h500, 32'h600, 32'h0);
        expect_idle("t4.c0");
        expect_idle("t4.c1");

        // Test 5: second request accepted on the first's last handshake.
        accept_req(4'h5, 32'h0, 32'h100, 32'h20);
        req_valid = 1'b1;
        req_id    = 4'h6;
        req_src   = 32'h40;
        req_dst   = 32'h200;
        req_num   = 32'h20;
        req_opt   = {4'hA, 4'h6};
        @(negedge clk);
        chunk_ready = 1'b1;
        #1;
        chk("t5.a_valid", chunk_valid, 1'b1);
        chk("t5.a_src", chunk_src, 32'h0);
        chk("t5.a_last", chunk_last, 1'b1);
        chk("t5.a_id", chunk_id, 4'h5);
        chk("t5.req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chunk_cycle("t5.b", 1'b1, 4'h6, 32'h40, 32'h200, 32'h20, 1'b1);
        expect_idle("t5.end");

        // Test 6: stall for five cycles mid-transfer.
        accept_req(4'h7, 32'h0, 32'h0, 32'h3000);
        chunk_cycle("t6.c0", 1'b1, 4'h7, 32'h0, 32'h0, 32'h1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chunk_cycle("t6.stall", 1'b0, 4'h7, 32'h1000, 32'h1000, 32'h1000, 1'b0);
        end
        chunk_cycle("t6.c1", 1'b1, 4'h7, 32'h1000, 32'h1000, 32'h1000, 1'b0);
        chunk_cycle("t6.c2", 1'b1, 4'h7, 32'h2000, 32'h2000, 32'h1000, 1'b1);
        expect_idle("t6.end");

        // Test 7: source address wraps at the top of the address space.
        accept_req(4'h8, 32'hFFFF_FFF8, 32'h10, 32'h10);
        chunk_cycle("t7.c0", 1'b1, 4'h8, 32'hFFFF_FFF8, 32'h10, 32'h8, 1'b0);
        chunk_cycle("t7.c1", 1'b1, 4'h8, 32'h0, 32'h18, 32'h8, 1'b1);
        expect_idle("t7.end");

        // Test 8: reset during split drops the request; next request is normal.
        accept_req(4'h9, 32'h0, 32'h0, 32'h3000);
        chunk_cycle("t8.c0", 1'b1, 4'h9, 32'h0, 32'h0, 32'h1000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t8.rst_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("t8.valid", chunk_valid, 1'b0);
        chk("t8.last", chunk_last, 1'b0);
        chk("t8.busy", busy, 1'b0);
        accept_req(4'hB, 32'h100, 32'h1F80, 32'h100);
        chunk_cycle("t8.n0", 1'b1, 4'hB, 32'h100, 32'h1F80, 32'h80, 1'b0);
        chunk_cycle("t8.n1", 1'b1, 4'hB, 32'h180, 32'h2000, 32'h80, 1'b1);
        expect_idle("t8.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
